sram_row_streamer: RTL and testbench
====================================

// Module: sram_row_streamer
// PURPOSE
//  Read sequencer directly upstream of sram_array_dist.
//  On start, issues a burst of row reads (base_addr, num_rows) to the SRAM array.
//  Returns each full COUNT*DATA_WIDTH row on a valid/ready stream to the MAC array.
//  A 2-entry skid FIFO absorbs the 1-cycle SRAM read latency, so backpressure never loses a row.
// PARAMETERS
//  COUNT       128  parallel SRAM banks / MAC lanes per row
//  DATA_WIDTH  16   bits per bank word
//  HEIGHT      128  rows per bank; need not be a power of two
//  ADDR_BITS   7    row address width; must satisfy HEIGHT <= 2**ADDR_BITS
// PORTS
//  clk           in   1                 clock, rising edge
//  rst_b         in   1                 asynchronous active-low reset
//  start         in   1                 burst request; sampled only in IDLE
//  base_addr     in   ADDR_BITS         first row of the burst
//  num_rows      in   ADDR_BITS+1       rows in the burst; 0 = empty burst, >HEIGHT clamped to HEIGHT
//  busy          out  1                 high from accepted start until done
//  done          out  1                 1-cycle pulse; burst complete
//  mem_addr      out  ADDR_BITS         to sram_array_dist addr
//  mem_en        out  1                 to sram_array_dist mem_en; registered
//  mem_write_en  out  1                 tied 0; this block only reads
//  mem_rd_data   in   COUNT*DATA_WIDTH  from sram_array_dist mem_data_out
//  row_valid     out  1                 row_data holds a valid row
//  row_ready     in   1                 consumer accepts; transfer = row_valid & row_ready
//  row_data      out  COUNT*DATA_WIDTH  row payload, lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//  row_last      out  1                 qualifies the final row of the burst
//  row_idx       out  ADDR_BITS         SRAM address the current row came from
// BEHAVIOUR
//  Reset values: every output, FSM, counters and FIFO are 0; the FSM enters IDLE.
//  SRAM timing: data for a read issued with mem_en=1 at edge N appears on mem_rd_data after edge N+1.
//  FSM states: IDLE, ISSUE, DRAIN.
//   IDLE->ISSUE on start with num_rows!=0. Latch base_addr and min(num_rows,HEIGHT); set busy.
//   IDLE with start and num_rows==0: no reads; done=1 next cycle; busy stays 0.
//   ISSUE->DRAIN when the last read has been issued.
//   DRAIN->IDLE when the last row transfers. done=1 and busy=0 in the following cycle.
//  Start latency: start sampled at edge E0 -> mem_en=1 during E0..E1 -> row_valid=1 from E2.
//  Issue rule: issue a read only if (FIFO occupancy + reads in flight - pops this cycle) < 2.
//   FIFO never overflows.
//   With row_ready held high, throughput is 1 row/cycle.
//  Address: increments per issued read; wraps HEIGHT-1 -> 0. row_idx follows the same sequence.
//  Stream rules:
//   row_data, row_last and row_idx are stable while row_valid & !row_ready.
//   row_valid never drops without a transfer.
//   row_ready may toggle at any time.
//  row_last is high only with the num_rows-th row.
//  start while busy: ignored; no error flag.
//  Async reset mid-burst: all state clears immediately. An in-flight read is discarded.
//   No row_valid and no done until a new start.
//  mem_write_en is constant 0. mem_en is 0 outside ISSUE.
// STRUCTURE
//  Package rlnn_mem_pkg:
//   stream_state_e enum {IDLE, ISSUE, DRAIN}
//   localparam SKID_DEPTH = 2
//   function clamp_rows()
//  Sub-module row_skid_fifo: 2-entry, 1-cycle pointer FIFO (wr_en, din, rd_en, dout, occupancy).
//   Each entry stores {last, idx, data}.
//  Top level: FSM, issue counter, in-flight flag pipelined with mem_en, wrapping address counter.
// TESTING
//  1 Reset: assert rst_b=0 mid-stream -> all outputs 0 same cycle. After release, no row_valid without start.
//  2 Basic: base=0, num_rows=4, row_ready=1 -> rows 0..3 on 4 consecutive cycles from E2.
//    row_last only on row 3; done at E6+1.
//  3 Wrap: HEIGHT=128, base=126, num_rows=4 -> row_idx 126,127,0,1; data matches the SRAM preload.
//  4 Backpressure: num_rows=8, row_ready random 50% -> all 8 rows in order, no loss or duplication.
//    Payload stable while stalled; FIFO occupancy <= 2.
//  5 Edge counts: num_rows=0 -> done pulse, mem_en never 1. num_rows=200 -> exactly 128 rows.
//  6 start pulsed during busy -> ignored; the burst completes with the original parameters.

Source files
------------

// File: rtl/sram_row_streamer_pkg.sv
// Shared types and helpers for the SRAM row streamer.
package rlnn_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } stream_state_e;

    // Entries in the row skid FIFO.
    localparam int SKID_DEPTH = 2;

    // Bursts longer than the array are cut down to one full pass.
    function automatic int unsigned clamp_rows(input int unsigned n, input int unsigned height);
        return (n > height) ? height : n;
    endfunction

endpackage

// File: rtl/sram_row_streamer_if.sv
// Burst control, SRAM read port and row stream of the SRAM row streamer.
// Row stream handshake: a row transfers on every rising edge where
// row_valid & row_ready; once row_valid is up, row_data/row_last/row_idx hold
// steady and row_valid stays up until that transfer, while row_ready may
// change freely in any cycle.
interface sram_row_streamer_if #(
    parameter int ADDR_BITS = 7,
    parameter int ROW_W     = 2048
);
    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic [ADDR_BITS:0]   num_rows;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_en;
    logic                 mem_write_en;
    logic [ROW_W-1:0]     mem_rd_data;
    logic                 row_valid;
    logic                 row_ready;
    logic [ROW_W-1:0]     row_data;
    logic                 row_last;
    logic [ADDR_BITS-1:0] row_idx;

    // Streamer side.
    modport master (
        input  start, base_addr, num_rows, mem_rd_data, row_ready,
        output busy, done, mem_addr, mem_en, mem_write_en,
               row_valid, row_data, row_last, row_idx
    );

    // Controller / SRAM / consumer side.
    modport slave (
        output start, base_addr, num_rows, mem_rd_data, row_ready,
        input  busy, done, mem_addr, mem_en, mem_write_en,
               row_valid, row_data, row_last, row_idx
    );
endinterface

// File: rtl/sram_row_streamer_skid_fifo.sv
// Two-entry pointer FIFO holding {last, idx, data} rows between the SRAM and
// the row stream. A write into a full FIFO is legal only together with a read.
module row_skid_fifo
    import rlnn_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         rd_en,
    output logic [W-1:0] dout,
    output logic [1:0]   occupancy
);
    logic [W-1:0] mem_q [SKID_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    assign dout      = mem_q[rd_ptr_q];
    assign occupancy = count_q;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_en) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end
endmodule

// File: rtl/sram_row_streamer.sv
// Burst read sequencer: issues row reads to sram_array_dist and returns each
// row on a valid/ready stream. The read data register of the SRAM keeps its
// value while mem_en is low, so a landed row that finds the FIFO full simply
// waits on mem_rd_data; issue is throttled so that never collides with the
// next read landing.
module sram_row_streamer
    import rlnn_mem_pkg::*;
#(
    parameter int          COUNT      = 128,
    parameter int          DATA_WIDTH = 16,
    parameter int unsigned HEIGHT     = 128,
    parameter int          ADDR_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 rst_b,
    sram_row_streamer_if.master  bus,
    output stream_state_e        dbg_state
);
    localparam int ROW_W   = COUNT * DATA_WIDTH;
    localparam int CNT_W   = ADDR_BITS + 1;
    localparam int ENTRY_W = 1 + ADDR_BITS + ROW_W;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(HEIGHT - 1);

    stream_state_e        state_q, state_d;
    logic                 mem_en_q, mem_en_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     rows_left_q, rows_left_d;  // reads not yet sampled by the SRAM
    logic                 done_q, done_d;
    logic                 infl_q;                    // row data sits on mem_rd_data
    logic [ADDR_BITS-1:0] infl_idx_q;
    logic                 infl_last_q;

    logic [1:0]           occ;
    logic                 fifo_wr, fifo_rd, row_valid, issue_last, infl_next, can_issue;
    logic [2:0]           commit_next;
    logic [ENTRY_W-1:0]   fifo_dout;

    // Flow control: rows committed after this edge must leave room for one more read.
    always_comb begin
        row_valid   = (occ != 2'd0);
        fifo_rd     = row_valid & bus.row_ready;
        fifo_wr     = infl_q & ((occ != 2'd2) | fifo_rd);
        issue_last  = (rows_left_q == CNT_W'(1));
        infl_next   = mem_en_q | (infl_q & ~fifo_wr);
        commit_next = {1'b0, occ} + {2'b0, fifo_wr} - {2'b0, fifo_rd} + {2'b0, infl_next};
        can_issue   = (commit_next <= 3'd2);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, read issue, address/count update and done pulse.
    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        addr_d      = addr_q;
        rows_left_d = rows_left_q;
        done_d      = 1'b0;
        if (mem_en_q) begin
            addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_BITS'(1);
            rows_left_d = rows_left_q - CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_rows == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        addr_d      = bus.base_addr;
                        rows_left_d = CNT_W'(clamp_rows(32'(bus.num_rows), HEIGHT));
                    end
                end
            end
            ISSUE: begin
                if (mem_en_q && issue_last) state_d  = DRAIN;
                else                        mem_en_d = can_issue;
            end
            DRAIN: begin
                if (fifo_rd && fifo_dout[ENTRY_W-1]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read port registers and the in-flight row tag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_en_q    <= 1'b0;
            addr_q      <= '0;
            rows_left_q <= '0;
            done_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_idx_q  <= '0;
            infl_last_q <= 1'b0;
        end else begin
            mem_en_q    <= mem_en_d;
            addr_q      <= addr_d;
            rows_left_q <= rows_left_d;
            done_q      <= done_d;
            infl_q      <= infl_next;
            if (mem_en_q) begin
                infl_idx_q  <= addr_q;
                infl_last_q <= issue_last;
            end
        end
    end

    row_skid_fifo #(.W(ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .wr_en     (fifo_wr),
        .din       ({infl_last_q, infl_idx_q, bus.mem_rd_data}),
        .rd_en     (fifo_rd),
        .dout      (fifo_dout),
        .occupancy (occ)
    );

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_write_en = 1'b0;
    assign bus.row_valid    = row_valid;
    assign bus.row_data     = fifo_dout[ROW_W-1:0];
    assign bus.row_idx      = fifo_dout[ROW_W +: ADDR_BITS];
    assign bus.row_last     = fifo_dout[ENTRY_W-1];
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_sram_row_streamer.sv
// Bench for sram_row_streamer: SRAM read model, directed bursts, and a
// scoreboard of expected {last, idx} rows checked by a stream monitor.
module tb_sram_row_streamer;
    import rlnn_mem_pkg::*;

    localparam int COUNT  = 128;
    localparam int DW     = 16;
    localparam int HEIGHT = 128;
    localparam int AB     = 7;
    localparam int ROW_W  = COUNT * DW;
    localparam int EW     = AB + 1;

    logic          clk;
    logic          rst_b;
    stream_state_e dbg_state;
    sram_row_streamer_if #(.ADDR_BITS(AB), .ROW_W(ROW_W)) bus ();

    sram_row_streamer #(.COUNT(COUNT), .DATA_WIDTH(DW), .HEIGHT(HEIGHT), .ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [EW-1:0] exp_q[$];
    logic          rand_ready  = 1'b0;
    int            mem_en_cycles = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane i of row a holds {1'b0, a, i}.
    function automatic logic [ROW_W-1:0] pattern(input logic [AB-1:0] a);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < COUNT; i++) r[i*DW +: DW] = {1'b0, a, i[7:0]};
        return r;
    endfunction

    // SRAM model: one-cycle read, output register holds when not enabled.
    logic [ROW_W-1:0] sram [HEIGHT];
    initial begin
        for (int a = 0; a < HEIGHT; a++) sram[a] = pattern(AB'(a));
        bus.mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rd_data <= sram[bus.mem_addr];
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AB-1:0] idx, input logic last);
        exp_q.push_back({last, idx});
    endtask

    task automatic push_seq(input int base, input int count);
        for (int k = 0; k < count; k++) push_exp(AB'((base + k) % HEIGHT), k == count - 1);
    endtask

    task automatic pulse_start(input logic [AB-1:0] b, input logic [AB:0] n);
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.num_rows  = n;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        check({name, " done seen"}, {31'd0, bus.done}, 32'd1);
        tick();
        check({name, " all rows out"}, exp_q.size(), 32'd0);
    endtask

    // Random backpressure source.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.row_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic             stall_pend = 1'b0;
    logic [ROW_W-1:0] held_data;
    logic [AB-1:0]    held_idx;
    logic             held_last;

    always @(negedge clk) begin
        if (!rst_b) begin
            stall_pend = 1'b0;
        end else begin
            if (bus.mem_en) mem_en_cycles++;
            if (stall_pend) begin
                vectors++;
                if (!(bus.row_valid && bus.row_data == held_data &&
                      bus.row_idx == held_idx && bus.row_last == held_last)) begin
                    miscompares++;
                    $display("FAIL stall_stable: valid=%0b idx=%0d last=%0b, expected valid=1 idx=%0d last=%0b",
                             bus.row_valid, bus.row_idx, bus.row_last, held_idx, held_last);
                end
            end
            if (bus.row_valid && bus.row_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_row: got idx=%0d last=%0b, expected no row", bus.row_idx, bus.row_last);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    if ({bus.row_last, bus.row_idx} !== e) begin
                        miscompares++;
                        $display("FAIL row_tag: got last=%0b idx=%0d, expected last=%0b idx=%0d",
                                 bus.row_last, bus.row_idx, e[AB], e[AB-1:0]);
                    end
                    vectors++;
                    if (bus.row_data !== pattern(e[AB-1:0])) begin
                        miscompares++;
                        $display("FAIL row_data: idx=%0d low word got %h, expected %h",
                                 e[AB-1:0], bus.row_data[31:0], pattern(e[AB-1:0]) >> 0 & 32'hffff_ffff);
                    end
                end
            end
            stall_pend = bus.row_valid && !bus.row_ready;
            held_data  = bus.row_data;
            held_idx   = bus.row_idx;
            held_last  = bus.row_last;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_b         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;
        bus.row_ready = 1'b0;
        #2;
        check("reset busy",      {31'd0, bus.busy},      32'd0);
        check("reset row_valid", {31'd0, bus.row_valid}, 32'd0);
        check("reset mem_en",    {31'd0, bus.mem_en},    32'd0);
        tick();
        tick();
        rst_b = 1'b1;
        tick();

        // Basic burst with exact start latency and done timing.
        bus.row_ready = 1'b1;
        push_exp(7'd0, 1'b0); push_exp(7'd1, 1'b0); push_exp(7'd2, 1'b0); push_exp(7'd3, 1'b1);
        pulse_start(7'd0, 8'd4);                          // after E0
        check("basic mem_en E0",   {31'd0, bus.mem_en}, 32'd1);
        check("basic mem_addr E0", {25'd0, bus.mem_addr}, 32'd0);
        check("basic busy E0",     {31'd0, bus.busy},   32'd1);
        check("mem_write_en",      {31'd0, bus.mem_write_en}, 32'd0);
        tick();                                           // after E1
        check("basic valid E1",    {31'd0, bus.row_valid}, 32'd0);
        tick();                                           // after E2
        check("basic valid E2",    {31'd0, bus.row_valid}, 32'd1);
        check("basic idx E2",      {25'd0, bus.row_idx},   32'd0);
        tick(); tick(); tick(); tick();                   // after E6
        check("basic done E6",     {31'd0, bus.done}, 32'd1);
        check("basic busy E6",     {31'd0, bus.busy}, 32'd0);
        check("basic rows out",    exp_q.size(), 32'd0);
        tick();
        check("basic done pulse",  {31'd0, bus.done}, 32'd0);

        // Address wrap.
        push_exp(7'd126, 1'b0); push_exp(7'd127, 1'b0); push_exp(7'd0, 1'b0); push_exp(7'd1, 1'b1);
        pulse_start(7'd126, 8'd4);
        wait_done("wrap", 40);

        // Single-row burst at the top address.
        push_exp(7'd127, 1'b1);
        pulse_start(7'd127, 8'd1);
        wait_done("single", 20);

        // Backpressure.
        push_seq(20, 8);
        rand_ready = 1'b1;
        pulse_start(7'd20, 8'd8);
        wait_done("backpressure", 200);
        rand_ready = 1'b0;
        bus.row_ready = 1'b1;
        tick();

        // Empty burst.
        mem_en_cycles = 0;
        pulse_start(7'd5, 8'd0);
        check("empty done",  {31'd0, bus.done}, 32'd1);
        check("empty busy",  {31'd0, bus.busy}, 32'd0);
        tick();
        check("empty done pulse", {31'd0, bus.done}, 32'd0);
        tick(); tick(); tick();
        check("empty no reads", mem_en_cycles, 32'd0);

        // Oversized burst clamps to HEIGHT rows.
        push_seq(5, 128);
        pulse_start(7'd5, 8'd200);
        wait_done("clamp", 400);

        // Start while busy is ignored.
        push_seq(10, 5);
        rand_ready = 1'b1;
        pulse_start(7'd10, 8'd5);
        tick();
        pulse_start(7'd50, 8'd3);
        wait_done("start_busy", 200);
        rand_ready = 1'b0;
        tick(); tick(); tick();
        check("start_busy no second burst", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of a stalled burst.
        bus.row_ready = 1'b0;
        pulse_start(7'd40, 8'd8);
        tick(); tick(); tick();
        check("pre-reset valid", {31'd0, bus.row_valid}, 32'd1);
        rst_b = 1'b0;
        #1;
        check("mid reset busy",      {31'd0, bus.busy},      32'd0);
        check("mid reset valid",     {31'd0, bus.row_valid}, 32'd0);
        check("mid reset mem_en",    {31'd0, bus.mem_en},    32'd0);
        check("mid reset done",      {31'd0, bus.done},      32'd0);
        check("mid reset row_idx",   {25'd0, bus.row_idx},   32'd0);
        check("mid reset row_last",  {31'd0, bus.row_last},  32'd0);
        check("mid reset mem_addr",  {25'd0, bus.mem_addr},  32'd0);
        check("mid reset row_data",  {31'd0, bus.row_data == '0}, 32'd1);
        tick(); tick();
        rst_b = 1'b1;
        bus.row_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post reset quiet", {30'd0, bus.row_valid, bus.done}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
